mem_arbiter: RTL and testbench

//  Shares the single-ported RAM between the icache miss port and the dcache miss port.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the icache and dcache miss ports.
// One request is latched per transaction, and the RAM is driven only from those latched values.
// The winner is acknowledged by a one-cycle low pulse on its wait line.
// A transaction that gets no ram_ready for MAX_WAIT cycles is aborted with a timeout pulse.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the grant on simultaneous
// requests. Without it, the dcache always wins ties.
module mem_arbiter #(
  parameter int WORD_W   = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              timeout
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] lat_addr_q, lat_store_q;
  logic              lat_wen_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] iload_q, dload_q;

  logic              d_req;
  logic              in_acc;
  logic              expired;
  logic              done;
  logic              ack_i, ack_d;
  logic              grant_i, grant_d;
  logic [WORD_W-1:0] resp;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
  grant_t last_grant_q;
`endif

  // Transaction status: completion, timeout, and the acknowledge seen by each requester.
  always_comb begin
    d_req   = dREN | dWEN;
    in_acc  = (state_q != IDLE);
    expired = in_acc && !ram_ready && (cnt_q == CNT_LAST);
    done    = in_acc && (ram_ready || expired);
    // A requester that dropped its request after the grant gets no acknowledge.
    ack_i   = done && (state_q == I_ACC) && iREN;
    ack_d   = done && (state_q == D_ACC) && d_req;
    resp    = expired ? '0 : ramload;
  end

  // Grant decision in IDLE. The dcache wins ties unless round-robin is enabled.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (d_req && iREN) grant_d = (last_grant_q == GRANT_I);
      else               grant_d = d_req;
`else
      grant_d = d_req;
`endif
      grant_i = iREN && !grant_d;
    end
  end

  // Next-state logic. Every access returns to IDLE, so back-to-back transactions are
  // separated by exactly one turnaround cycle.
  // NOTE: state_d gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_d) state_d = D_ACC;
               else if (grant_i) state_d = I_ACC;
      I_ACC,
      D_ACC:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM sees only latched values. Because the strobes decode the state register,
  // asserting reset clears them without waiting for a clock edge.
  always_comb begin
    ramREN   = (state_q == I_ACC) || ((state_q == D_ACC) && !lat_wen_q);
    ramWEN   = (state_q == D_ACC) && lat_wen_q;
    ramaddr  = lat_addr_q;
    ramstore = lat_store_q;
    iwait    = !ack_i;
    dwait    = !ack_d;
    iload    = ack_i ? resp : iload_q;
    dload    = ack_d ? resp : dload_q;
    timeout  = expired;
  end

  // State register, request latch, saturating wait counter, and held load values.
  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      lat_addr_q  <= '0;
      lat_store_q <= '0;
      lat_wen_q   <= 1'b0;
      cnt_q       <= '0;
      iload_q     <= '0;
      dload_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        lat_addr_q  <= daddr;
        lat_store_q <= dstore;
        lat_wen_q   <= dWEN;
        cnt_q       <= '0;
      end else if (grant_i) begin
        lat_addr_q  <= iaddr;
        lat_wen_q   <= 1'b0;
        cnt_q       <= '0;
      end else if (in_acc && !ram_ready && (cnt_q != CNT_LAST)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (ack_i) iload_q <= resp;
      if (ack_d) dload_q <= resp;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Record which side was served last, so that the next tie goes to the other side.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        last_grant_q <= GRANT_I;
    else if (grant_d) last_grant_q <= GRANT_D;
    else if (grant_i) last_grant_q <= GRANT_I;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter, built with MAX_WAIT=4.
// Inputs are driven on the falling edge, and outputs are checked 1 time unit later.
// Expected tie-break results follow ARB_ROUND_ROBIN_EN when that macro is defined.
module tb_mem_arbiter;

  localparam int W = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         nRST;
  logic         iREN, dREN, dWEN, ram_ready;
  logic [W-1:0] iaddr, daddr, dstore, ramload;
  logic         iwait, dwait, ramREN, ramWEN, timeout;
  logic [W-1:0] iload, dload, ramaddr, ramstore;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.WORD_W(W), .MAX_WAIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] first_addr, second_addr, prev_iload;

    // Reset state
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    #2;
    check("rst_iwait",   iwait,   1);
    check("rst_dwait",   dwait,   1);
    check("rst_ramREN",  ramREN,  0);
    check("rst_ramWEN",  ramWEN,  0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_loads",   iload | dload, 0);
    check("rst_timeout", timeout, 0);
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);

    // Lone read: RAM answers on the third access cycle; an address change mid-access is ignored
    iREN = 1; iaddr = 32'h40;
    #1 check("rd_idle_iwait", iwait, 1);
    @(negedge CLK); iaddr = 32'h80;
    #1 check("rd_ramREN",  ramREN,  1);
    check("rd_ramWEN",  ramWEN,  0);
    check("rd_ramaddr", ramaddr, 32'h40);
    check("rd_iwait_c0", iwait, 1);
    @(negedge CLK);
    #1 check("rd_iwait_c1", iwait, 1);
    @(negedge CLK); ram_ready = 1; ramload = 32'h8C220004;
    #1 check("rd_ack_iwait", iwait, 0);
    check("rd_ack_iload", iload, 32'h8C220004);
    check("rd_ack_dwait", dwait, 1);
    @(negedge CLK); iREN = 0; ram_ready = 0; ramload = 32'hFFFF_FFFF;
    #1 check("rd_idle_ramREN", ramREN, 0);
    check("rd_hold_iload", iload, 32'h8C220004);
    check("rd_idle_iwait2", iwait, 1);

    // Collision iREN + dWEN: the write goes first, then the read after one IDLE cycle
    @(negedge CLK); iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    @(negedge CLK);
    #1 check("col_ramWEN",   ramWEN,   1);
    check("col_ramREN",   ramREN,   0);
    check("col_ramaddr",  ramaddr,  32'h100);
    check("col_ramstore", ramstore, 32'hDEADBEEF);
    ram_ready = 1; ramload = 32'h0;
    #1 check("col_dwait", dwait, 0);
    check("col_iwait_stall", iwait, 1);
    @(negedge CLK); dWEN = 0; ram_ready = 0;
    #1 check("col_turn_ramWEN", ramWEN, 0);
    check("col_turn_ramREN", ramREN, 0);
    check("col_turn_iwait",  iwait,  1);
    @(negedge CLK);
    #1 check("col_i_ramREN",  ramREN,  1);
    check("col_i_ramaddr", ramaddr, 32'h44);
    ram_ready = 1; ramload = 32'h11112222;
    #1 check("col_i_iwait", iwait, 0);
    check("col_i_iload", iload, 32'h11112222);
    check("col_i_dwait", dwait, 1);
    @(negedge CLK); iREN = 0; ram_ready = 0;

    // A lone dcache read makes D the last grant; then iREN + dREN arrive together
    @(negedge CLK); dREN = 1; daddr = 32'h200;
    @(negedge CLK); ram_ready = 1; ramload = 32'hAAAA0001;
    #1 check("dr_ramREN", ramREN, 1);
    check("dr_dwait",  dwait,  0);
    check("dr_dload",  dload,  32'hAAAA0001);
    @(negedge CLK); ram_ready = 0; iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h204;
    first_addr  = RR ? 32'h300 : 32'h204;
    second_addr = RR ? 32'h204 : 32'h300;
    @(negedge CLK);
    #1 check("tie1_ramaddr", ramaddr, first_addr);
    ram_ready = 1; ramload = 32'hBBBB0002;
    #1 check("tie1_iwait", iwait, RR ? 1'b0 : 1'b1);
    check("tie1_dwait", dwait, RR ? 1'b1 : 1'b0);
    @(negedge CLK); ram_ready = 0;
    if (RR) iREN = 0; else dREN = 0;
    @(negedge CLK);
    #1 check("tie2_ramaddr", ramaddr, second_addr);
    ram_ready = 1; ramload = 32'hCCCC0003;
    #1 check("tie2_iwait", iwait, RR ? 1'b1 : 1'b0);
    check("tie2_dwait", dwait, RR ? 1'b0 : 1'b1);
    @(negedge CLK); ram_ready = 0; iREN = 0; dREN = 0;
    prev_iload = RR ? 32'hBBBB0002 : 32'hCCCC0003;

    // Timeout with MAX_WAIT=4: three silent cycles, then an abort on the fourth
    @(negedge CLK); dREN = 1; daddr = 32'h500; ramload = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1 check($sformatf("to_wait_c%0d", c), {timeout, dwait}, 2'b01);
    end
    @(negedge CLK);
    #1 check("to_pulse", timeout, 1);
    check("to_dwait", dwait,   0);
    check("to_dload", dload,   0);
    check("to_iwait", iwait,   1);
    @(negedge CLK); dREN = 0;
    #1 check("to_after_timeout", timeout, 0);
    check("to_after_ramREN", ramREN, 0);
    check("to_hold_dload",   dload,  0);

    // A request dropped after its grant: the access completes but no acknowledge is given
    @(negedge CLK); iREN = 1; iaddr = 32'h900;
    @(negedge CLK); iREN = 0; ram_ready = 1; ramload = 32'h55;
    #1 check("drop_ramREN", ramREN, 1);
    check("drop_iwait",  iwait,  1);
    check("drop_iload",  iload,  prev_iload);
    @(negedge CLK); ram_ready = 0;

    // dREN + dWEN is a write; mid-access input changes are ignored; reset drops the strobes at once
    @(negedge CLK); dREN = 1; dWEN = 1; daddr = 32'h600; dstore = 32'h12345678;
    @(negedge CLK); daddr = 32'h700; dstore = 32'h0;
    #1 check("mid_ramWEN",   ramWEN,   1);
    check("mid_ramREN",   ramREN,   0);
    check("mid_ramaddr",  ramaddr,  32'h600);
    check("mid_ramstore", ramstore, 32'h12345678);
    #1 nRST = 0;
    #1 check("mid_rst_ramWEN", ramWEN, 0);
    check("mid_rst_ramREN", ramREN, 0);
    check("mid_rst_dwait",  dwait,  1);
    check("mid_rst_ramaddr", ramaddr, 0);
    @(negedge CLK); dREN = 0; dWEN = 0; nRST = 1;
    @(negedge CLK);
    #1 check("post_rst_strobes", {ramREN, ramWEN}, 2'b00);
    check("post_rst_waits", {iwait, dwait}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
